run_ctrl: RTL

Program-run sequencer and data-memory port arbiter for the single-cycle core, instantiated in `top_level` between the instruction-decode/PC logic and `data_mem`. A `reset` pulse starts a program. The block enables PC advance until the decoded halt instruction retires (or a watchdog expires), then holds `done`. It also shares the single data-memory port between the core and a debug/loader port; the core has priority, and a starvation limit forces the core to give up the port when the debug side has waited too long.

---
 rtl/run_pkg.sv | 14 +
 rtl/dmem_arb.sv | 65 ++++++
 rtl/run_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/run_pkg.sv
// Shared types and default widths for the run sequencer and its data-memory arbiter.
package run_pkg;

  localparam int RUN_AW = 8;
  localparam int RUN_DW = 8;
  localparam int RUN_CW = 16;

  typedef enum logic [1:0] {
    RST,
    RUN,
    DONE
  } run_state_t;

endpackage

// File: rtl/dmem_arb.sv
// Data-memory port arbiter: core has priority while running, the debug port steals
// the port after it has been denied STARVE_LIM consecutive cycles.
module dmem_arb
  import run_pkg::*;
#(
  parameter int AW         = RUN_AW,
  parameter int DW         = RUN_DW,
  parameter int STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run_active,
  input  logic          core_mem_req,
  input  logic          core_mem_wr,
  input  logic [AW-1:0] core_mem_addr,
  input  logic [DW-1:0] core_mem_wdata,
  input  logic          dbg_req,
  input  logic          dbg_wr,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          stall,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata
);

  localparam int SW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

  logic [SW-1:0] starve_q, starve_d;
  logic          steal;
  logic          core_gnt;

  always_comb begin
    // The steal decision uses only the registered wait count, never this cycle's grant.
    steal     = run_active && dbg_req && (starve_q == SW'(STARVE_LIM));
    core_gnt  = run_active && core_mem_req && !steal;
    dbg_gnt   = dbg_req && !core_gnt;
    stall     = steal;
    mem_en    = core_gnt || dbg_gnt;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_gnt) begin
      mem_wr    = core_mem_wr;
      mem_addr  = core_mem_addr;
      mem_wdata = core_mem_wdata;
    end else if (dbg_gnt) begin
      mem_wr    = dbg_wr;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
    starve_d = (run_active && dbg_req && !dbg_gnt) ? starve_q + SW'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Program-run sequencer: RST/RUN/DONE FSM with a saturating cycle counter and watchdog,
// plus the shared data-memory port arbiter.
module run_ctrl
  import run_pkg::*;
#(
  parameter int          AW         = RUN_AW,
  parameter int          DW         = RUN_DW,
  parameter int          CW         = RUN_CW,
  parameter logic [CW-1:0] MAX_CYCLES = 16'hFFFF,
  parameter int          STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          halt,
  input  logic          core_mem_req,
  input  logic          core_mem_wr,
  input  logic [AW-1:0] core_mem_addr,
  input  logic [DW-1:0] core_mem_wdata,
  input  logic          dbg_req,
  input  logic          dbg_wr,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          pc_clr,
  output logic          pc_en,
  output logic          stall,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycle_count
);

  localparam logic [CW-1:0] CNT_LAST = MAX_CYCLES - CW'(1);

  run_state_t    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          timeout_q, timeout_d;
  logic          run_active;

  assign run_active  = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign timeout     = timeout_q;
  assign cycle_count = count_q;

  dmem_arb #(
    .AW         (AW),
    .DW         (DW),
    .STARVE_LIM (STARVE_LIM)
  ) u_arb (
    .clk            (clk),
    .reset          (reset),
    .run_active     (run_active),
    .core_mem_req   (core_mem_req),
    .core_mem_wr    (core_mem_wr),
    .core_mem_addr  (core_mem_addr),
    .core_mem_wdata (core_mem_wdata),
    .dbg_req        (dbg_req),
    .dbg_wr         (dbg_wr),
    .dbg_addr       (dbg_addr),
    .dbg_wdata      (dbg_wdata),
    .dbg_gnt        (dbg_gnt),
    .stall          (stall),
    .mem_en         (mem_en),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    timeout_d = timeout_q;
    pc_clr    = 1'b0;
    pc_en     = 1'b0;
    case (state_q)
      RST: begin
        pc_clr    = 1'b1;
        count_d   = '0;
        timeout_d = 1'b0;
        state_d   = RUN;
      end
      RUN: begin
        pc_en   = !stall;
        count_d = (count_q == CNT_LAST) ? count_q : count_q + CW'(1);
        // A stalled halt is ignored; the instruction re-executes and is seen again.
        if (halt && !stall) begin
          state_d   = DONE;
          timeout_d = 1'b0;
        end else if (count_q == CNT_LAST) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = RST;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RST;
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end

endmodule
